fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of the single-cycle datapath.
- Owns the fetch PC and issues word requests to a variable-latency instruction memory over a req/ack handshake.
- Buffers returned instructions with their PCs in a small FIFO and presents them to the datapath over valid/ready.
- Handles PC redirects (taken branch/jump, jalr target) from the datapath by flushing and refetching.

Parameters:
DEPTH, 4, FIFO entries (power of two, ≥2)
RESET_PC, 32'h0000_0000, fetch address after reset

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
redirect  input  1  datapath requests PC change this cycle
redirect_pc  input  32  new fetch address; bits[1:0] forced to 0
imem_req  output  1  request to instruction memory, held until ack
imem_addr  output  32  word address of request, stable while imem_req=1
imem_ack  input  1  response valid, may assert in same cycle as imem_req
imem_rdata  input  32  instruction word, valid with imem_ack
inst_valid  output  1  FIFO head holds a valid instruction
inst_ready  input  1  datapath consumes head this cycle
inst  output  32  instruction at FIFO head
inst_pc  output  32  PC of head instruction
inst_pc4  output  32  inst_pc + 4, combinational

Behaviour:
- Reset: one clock and a synchronous active-high reset; clock port clk, reset port rst. State=IDLE, fpc=RESET_PC, FIFO empty, imem_req=0, imem_addr=RESET_PC, inst_valid=0, FIFO storage zeroed so inst=0, inst_pc=0.
- Only one request is outstanding at a time. imem_req is 1 exactly in states REQ and DROP. imem_addr is a register loaded on entry to REQ.
- Pop: inst_valid && inst_ready. cnt_next = cnt + (accepted ack) − pop.
- IDLE:
  - If cnt_next < DEPTH, go to REQ with imem_addr=fpc. After reset release, imem_req rises 1 cycle later.
  - imem_ack is ignored in IDLE.
- REQ:
  - ack && !redirect: write {imem_rdata, imem_addr} to FIFO and set fpc=imem_addr+4. If cnt_next < DEPTH, stay in REQ with imem_addr=fpc+4 (1 instr/cycle with zero-wait memory); otherwise go to IDLE.
  - !ack && redirect: set fpc=redirect_pc, flush FIFO, go to DROP. imem_addr holds the old value.
  - ack && redirect: drop the data, flush, set fpc=redirect_pc, stay in REQ with imem_addr=redirect_pc.
- DROP:
  - imem_req held with the old address until ack. On ack, discard the data and go to REQ with imem_addr=fpc.
  - A further redirect in DROP only updates fpc.
- Redirect in IDLE: flush, set fpc=redirect_pc, go to REQ the next cycle.
- Redirect priority:
  - Redirect beats pop and ack in the same cycle. The FIFO is empty and inst_valid=0 the next cycle.
  - A popped head is considered consumed by the datapath.
- FIFO full: no request is issued. The ack of the outstanding request always has a slot, guaranteed by the cnt_next rule.
- FIFO empty: inst_valid=0. There is no bypass, so the minimum ack→inst_valid latency is 1 cycle.
- Wrap-around: fpc increments modulo 2^32. FIFO pointers wrap modulo DEPTH.
- Reset mid-operation: the next cycle is in IDLE with imem_req=0. Any late ack is ignored, and fetch restarts at RESET_PC.

Decomposition:
- Shared package fetch_pkg: XLEN=32; fetch state encoding IDLE/REQ/DROP; RESET_PC default; INST_BYTES=4.
- Sub-module fetch_fifo: synchronous FIFO of {inst, pc}.
  - Inputs: push, pop, flush.
  - Outputs: count, head.
  - Flush has priority over push and pop.

Test Plan:
- Reset then zero-wait memory (ack=req), ready=1 → imem_addr 0,4,8,... one per cycle; inst_pc sequence 0,4,8 with inst_valid=1 from cycle 3; inst_pc4=inst_pc+4.
- DEPTH=4, ready=0, zero-wait memory → exactly 4 acks accepted, imem_req=0 after the 4th; ready=1 for 1 cycle → one new request at 0x10.
- Ack delayed 3 cycles, redirect to 0x100 one cycle after req at 0x8 → imem_addr stays 0x8 until ack, response dropped, next imem_addr=0x100, first inst_pc=0x100.
- Redirect to 0x200 in the same cycle as ack for 0x4 → 0x4 never enters the FIFO; next cycle imem_req=1 with imem_addr=0x200.
- FIFO full, redirect + inst_ready in the same cycle, redirect_pc=0x103 → inst_valid=0 next cycle; fetch resumes at 0x100.
- rst asserted while in REQ, ack arrives 2 cycles later → imem_req=0 the cycle after rst, ack ignored, requests restart at RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage.
package fetch_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned INST_BYTES = 4;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // Fetch sequencer states
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_DROP = 2'd2;

  // One buffered instruction together with the address it was fetched from
  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

  // Clear the byte-offset bits so every fetch address is word aligned
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
    return a & ~XLEN'(INST_BYTES - 1);
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction memory req/ack, datapath valid/ready, redirect.
interface fetch_unit_if;
  import fetch_pkg::*;

  logic            redirect;
  logic [XLEN-1:0] redirect_pc;
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ack;
  logic [XLEN-1:0] imem_rdata;
  logic            inst_valid;
  logic            inst_ready;
  logic [XLEN-1:0] inst;
  logic [XLEN-1:0] inst_pc;
  logic [XLEN-1:0] inst_pc4;

  // Fetch unit side
  modport master (
    input  redirect, redirect_pc, imem_ack, imem_rdata, inst_ready,
    output imem_req, imem_addr, inst_valid, inst, inst_pc, inst_pc4
  );

  // Memory + datapath side
  modport slave (
    output redirect, redirect_pc, imem_ack, imem_rdata, inst_ready,
    input  imem_req, imem_addr, inst_valid, inst, inst_pc, inst_pc4
  );

endinterface

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of {inst, pc}; flush wins over push and pop.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  fetch_entry_t             wdata,
  output fetch_entry_t             head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  fetch_entry_t   mem [DEPTH];
  logic [AW-1:0]  rd_ptr;
  logic [AW-1:0]  wr_ptr;

  // Pointer/count bookkeeping and storage writes; storage is only cleared by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      mem    <= '{default: '0};
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC owner, single-outstanding imem requester, inst buffer.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  fetch_unit_if.master  bus
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [1:0]      state;
  logic [XLEN-1:0] fpc;
  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] rpc;
  logic [CW-1:0]   count;
  logic [CW-1:0]   cnt_next;
  logic            pop;
  logic            acc;
  logic            room;
  fetch_entry_t    wdata;
  fetch_entry_t    head;

  assign rpc      = word_align(bus.redirect_pc);
  assign pop      = (count != '0) && bus.inst_ready;
  // Data is accepted only for a live request that is not being redirected away
  assign acc      = (state == ST_REQ) && bus.imem_ack && !bus.redirect;
  assign cnt_next = count + CW'(acc) - CW'(pop);
  assign room     = cnt_next < CW'(DEPTH);
  assign wdata    = '{inst: bus.imem_rdata, pc: addr_q};

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (acc),
    .pop   (pop),
    .flush (bus.redirect),
    .wdata (wdata),
    .head  (head),
    .count (count)
  );

  // Fetch sequencer: request issue, redirect handling and PC advance
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      fpc    <= RESET_PC;
      addr_q <= RESET_PC;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.redirect) begin
            fpc    <= rpc;
            addr_q <= rpc;
            state  <= ST_REQ;
          end else if (room) begin
            addr_q <= fpc;
            state  <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (bus.redirect) begin
            fpc <= rpc;
            if (bus.imem_ack) begin
              addr_q <= rpc;
            end else begin
              state <= ST_DROP;
            end
          end else if (bus.imem_ack) begin
            fpc <= addr_q + XLEN'(INST_BYTES);
            if (room) begin
              addr_q <= addr_q + XLEN'(INST_BYTES);
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        ST_DROP: begin
          // The stale request stays on the bus; only the target PC tracks redirects
          if (bus.redirect) begin
            fpc <= rpc;
          end
          if (bus.imem_ack) begin
            addr_q <= bus.redirect ? rpc : fpc;
            state  <= ST_REQ;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.imem_req   = (state == ST_REQ) || (state == ST_DROP);
  assign bus.imem_addr  = addr_q;
  assign bus.inst_valid = (count != '0);
  assign bus.inst       = head.inst;
  assign bus.inst_pc    = head.pc;
  assign bus.inst_pc4   = head.pc + XLEN'(INST_BYTES);

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit against a transaction-level fetch model.
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam int unsigned     DEPTH = 4;
  localparam logic [31:0]     RPC0  = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fetch_unit_if bus();

  fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RPC0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_1234;
  endfunction

  // Model: expected instruction stream and next sequential fetch address
  fetch_entry_t q[$];
  logic [31:0]  mpc = RPC0;
  bit           drop_pending = 0;
  int           stall = 0;
  int           since_rst = 0;
  int           first_req = -1;
  int           first_valid = -1;
  int           nacc = 0;
  int           npops = 0;

  // Memory responder state
  bit           mem_new = 1;
  int unsigned  mem_wait = 0;

  // Stimulus knobs (percentages / max ack wait)
  int unsigned  max_wait = 0, p_ready = 100, p_redir = 0, p_rst = 0, p_spur = 0;

  logic         prev_req = 0, prev_ack = 0, prev_rst = 1;
  logic [31:0]  prev_addr = '0;

  task automatic step();
    logic [31:0] r;
    @(negedge clk);
    rst             = ($urandom_range(99) < p_rst);
    bus.redirect    = !rst && ($urandom_range(99) < p_redir);
    r               = $urandom;
    case ($urandom_range(3))
      0:       bus.redirect_pc = 32'hFFFF_FFF0 | (r & 32'hF);
      default: bus.redirect_pc = r & 32'h0000_0FFF;
    endcase
    bus.inst_ready  = ($urandom_range(99) < p_ready);
    if (bus.imem_req) begin
      if (mem_new) begin
        mem_wait = $urandom_range(max_wait);
        mem_new  = 0;
      end
      bus.imem_ack   = (mem_wait == 0);
      bus.imem_rdata = inst_of(bus.imem_addr);
      if (mem_wait == 0) mem_new = 1;
      else mem_wait--;
    end else begin
      bus.imem_ack   = ($urandom_range(99) < p_spur);
      bus.imem_rdata = $urandom;
      mem_new        = 1;
    end
    #1;

    // Output checks against the model state built from earlier cycles
    check_eq("inst_valid", bus.inst_valid, q.size() != 0);
    if (q.size() != 0) begin
      check_eq("inst", bus.inst, q[0].inst);
      check_eq("inst_pc", bus.inst_pc, q[0].pc);
      check_eq("inst_pc4", bus.inst_pc4, q[0].pc + 32'd4);
    end
    if (q.size() == DEPTH) check_eq("req_when_full", bus.imem_req, 1'b0);
    if (prev_req && !prev_ack && !prev_rst) begin
      check_eq("req_held", bus.imem_req, 1'b1);
      check_eq("addr_held", bus.imem_addr, prev_addr);
    end
    if (stall >= 16) begin
      check_eq("progress_stall", stall, 0);
      stall = 0;
    end
    if (bus.imem_req && first_req < 0) first_req = since_rst;
    if (bus.inst_valid && first_valid < 0) first_valid = since_rst;

    // Advance the model across the coming clock edge
    if (rst) begin
      q.delete();
      mpc = RPC0; drop_pending = 0; stall = 0;
      since_rst = 0; first_req = -1; first_valid = -1; nacc = 0;
    end else begin
      since_rst++;
      if (bus.redirect) begin
        drop_pending = bus.imem_req && !bus.imem_ack;
        q.delete();
        mpc   = bus.redirect_pc & ~32'd3;
        stall = 0;
      end else begin
        bit accepted = 0;
        if (q.size() != 0 && bus.inst_ready) begin
          void'(q.pop_front());
          npops++;
        end
        if (bus.imem_req && bus.imem_ack) begin
          if (drop_pending) begin
            drop_pending = 0;
          end else begin
            check_eq("req_addr", bus.imem_addr, mpc);
            q.push_back('{inst: inst_of(mpc), pc: mpc});
            mpc += 32'd4;
            nacc++;
            accepted = 1;
          end
        end
        if (accepted || q.size() == DEPTH) stall = 0;
        else stall++;
      end
    end
    prev_req  = bus.imem_req;
    prev_ack  = bus.imem_ack;
    prev_addr = bus.imem_addr;
    prev_rst  = rst;
  endtask

  initial begin
    bus.redirect    = 0;
    bus.redirect_pc = '0;
    bus.imem_ack    = 0;
    bus.imem_rdata  = '0;
    bus.inst_ready  = 0;

    // Reset and reset-state checks
    p_rst = 100;
    repeat (3) step();
    @(posedge clk); #1;
    check_eq("rst_req", bus.imem_req, 1'b0);
    check_eq("rst_addr", bus.imem_addr, RPC0);
    check_eq("rst_valid", bus.inst_valid, 1'b0);
    check_eq("rst_inst", bus.inst, 32'h0);
    check_eq("rst_pc", bus.inst_pc, 32'h0);

    // Zero-wait memory, always ready: streaming from RESET_PC
    p_rst = 0; max_wait = 0; p_ready = 100; p_redir = 0; p_spur = 0;
    repeat (12) step();
    check_eq("first_req_lat", first_req, 1);
    check_eq("first_valid_lat", first_valid, 2);

    // Backpressure fills the FIFO, then a single pop admits one more fetch
    p_rst = 100; step();
    p_rst = 0; p_ready = 0;
    repeat (10) step();
    check_eq("fill_acks", nacc, DEPTH);
    @(posedge clk); #1;
    check_eq("full_no_req", bus.imem_req, 1'b0);
    p_ready = 100; step();
    p_ready = 0; repeat (6) step();
    check_eq("refill_acks", nacc, DEPTH + 1);

    // Random traffic: variable latency, redirects, spurious acks, resets
    max_wait = 3; p_ready = 70; p_redir = 6; p_rst = 1; p_spur = 20;
    repeat (3000) step();

    // Redirect-heavy traffic
    p_redir = 30; p_ready = 50;
    repeat (600) step();

    check_eq("pops_made", npops > 100, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
